// File: rtl/blink_monitor.sv
// Blink-line monitor: measures toggle-to-toggle half-period, locks on a stable rate,
// flags stuck lines and rate changes. Define BLINK_MONITOR_SYNC_EN for a 2-flop input synchroniser.
module blink_monitor #(
  parameter int unsigned      CBITS    = 28,
  parameter int unsigned      TOL      = 2,
  parameter int unsigned      LOCK_CNT = 4,
  parameter logic [CBITS-1:0] TIMEOUT  = {CBITS{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_in,
  output logic             edge_pulse,
  output logic             level,
  output logic [CBITS-1:0] half_period,
  output logic             period_vld,
  output logic             locked,
  output logic             mismatch,
  output logic             stuck
);

  localparam logic [CBITS-1:0] TolW     = CBITS'(TOL);
  localparam logic [3:0]       LockCntW = 4'(LOCK_CNT);

  typedef enum logic [1:0] {StIdle, StMeas, StTrack, StLocked} state_e;

  state_e           state_q, state_d;
  logic             s;
  logic             p_q;
  logic             edge_det;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       match_inc;
  logic [CBITS:0]   m_wide;
  logic [CBITS-1:0] m;
  logic [CBITS-1:0] diff;
  logic             in_tol;
  logic             timeout_hit;
  logic [CBITS-1:0] hp_d;
  logic             vld_d, locked_d, mis_d, stuck_d;

`ifdef BLINK_MONITOR_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], led_in};
  end
  assign s = sync_q[1];
`else
  assign s = led_in;
`endif

  assign edge_det = s ^ p_q;

  // Interval is cnt+1; clip to the counter width when cnt is all ones.
  assign m_wide    = {1'b0, cnt_q} + 1'b1;
  assign m         = m_wide[CBITS] ? {CBITS{1'b1}} : m_wide[CBITS-1:0];
  assign diff      = (m >= half_period) ? (m - half_period) : (half_period - m);
  assign in_tol    = (diff <= TolW);
  assign match_inc = match_q + 4'd1;

  // An edge in the same cycle as the timeout takes priority.
  assign timeout_hit = (state_q != StIdle) && (cnt_q == TIMEOUT) && !edge_det;

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    hp_d     = half_period;
    vld_d    = 1'b0;
    locked_d = locked;
    mis_d    = 1'b0;
    stuck_d  = 1'b0;

    if (state_q == StIdle || edge_det || timeout_hit) cnt_d = '0;
    else if (cnt_q != TIMEOUT)                         cnt_d = cnt_q + 1'b1;
    else                                               cnt_d = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (edge_det) state_d = StMeas;
      end
      StMeas: begin
        if (edge_det) begin
          state_d = StTrack;
          hp_d    = m;
          vld_d   = 1'b1;
          match_d = '0;
        end
      end
      StTrack: begin
        if (edge_det) begin
          hp_d  = m;
          vld_d = 1'b1;
          if (in_tol) begin
            match_d = match_inc;
            if (match_inc == LockCntW) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end else begin
            match_d = '0;
            mis_d   = 1'b1;
          end
        end
      end
      StLocked: begin
        if (edge_det) begin
          hp_d  = m;
          vld_d = 1'b1;
          if (!in_tol) begin
            state_d  = StTrack;
            locked_d = 1'b0;
            mis_d    = 1'b1;
            match_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout_hit) begin
      state_d  = StIdle;
      stuck_d  = 1'b1;
      locked_d = 1'b0;
      hp_d     = '0;
      match_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      p_q         <= 1'b0;
      cnt_q       <= '0;
      match_q     <= '0;
      edge_pulse  <= 1'b0;
      level       <= 1'b0;
      half_period <= '0;
      period_vld  <= 1'b0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= s;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      edge_pulse  <= edge_det;
      level       <= s;
      half_period <= hp_d;
      period_vld  <= vld_d;
      locked      <= locked_d;
      mismatch    <= mis_d;
      stuck       <= stuck_d;
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor: table of toggle intervals with expected responses,
// plus reset, asynchronous-reset and counter-width clipping sequences.
module tb_blink_monitor;

  localparam int unsigned CB = 28;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          led_in = 1'b0;

  logic          edge_pulse, level, period_vld, locked, mismatch, stuck;
  logic [CB-1:0] half_period;

  logic          edge2, level2, vld2, locked2, mis2, stuck2;
  logic [5:0]    hp2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  blink_monitor #(
    .CBITS   (CB),
    .TOL     (2),
    .LOCK_CNT(4),
    .TIMEOUT (28'd64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .edge_pulse (edge_pulse),
    .level      (level),
    .half_period(half_period),
    .period_vld (period_vld),
    .locked     (locked),
    .mismatch   (mismatch),
    .stuck      (stuck)
  );

  // Narrow counter with default TIMEOUT (all ones): exercises clipping of the interval.
  blink_monitor #(
    .CBITS   (6),
    .TOL     (2),
    .LOCK_CNT(4)
  ) dut_clip (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .edge_pulse (edge2),
    .level      (level2),
    .half_period(hp2),
    .period_vld (vld2),
    .locked     (locked2),
    .mismatch   (mis2),
    .stuck      (stuck2)
  );

  typedef struct {
    bit            tgl;
    int unsigned   gap;
    logic [CB-1:0] hp;
    logic          vld;
    logic          lck;
    logic          mis;
    logic          stk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit tgl, input int unsigned gap, input int unsigned hp,
                     input bit vld, input bit lck, input bit mis, input bit stk);
    vec_t v;
    v.tgl = tgl;
    v.gap = gap;
    v.hp  = CB'(hp);
    v.vld = vld;
    v.lck = lck;
    v.mis = mis;
    v.stk = stk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;

    // gap = cycles since the previous toggle (or previous check); tgl=0 means line held.
    add(1, 5,  0,  0, 0, 0, 0);  // IDLE -> MEAS, no measurement
    add(1, 8,  8,  1, 0, 0, 0);  // MEAS -> TRACK, first period_vld
    add(1, 8,  8,  1, 0, 0, 0);  // match 1
    add(1, 8,  8,  1, 0, 0, 0);  // match 2
    add(1, 8,  8,  1, 0, 0, 0);  // match 3
    add(1, 8,  8,  1, 1, 0, 0);  // match 4 -> locked
    add(1, 8,  8,  1, 1, 0, 0);
    add(1, 9,  9,  1, 1, 0, 0);  // jitter within tolerance
    add(1, 7,  7,  1, 1, 0, 0);
    add(1, 9,  9,  1, 1, 0, 0);
    add(1, 8,  8,  1, 1, 0, 0);
    add(1, 20, 20, 1, 0, 1, 0);  // rate change
    add(1, 20, 20, 1, 0, 0, 0);
    add(1, 20, 20, 1, 0, 0, 0);
    add(1, 20, 20, 1, 0, 0, 0);
    add(1, 20, 20, 1, 1, 0, 0);  // relocked at 20
    add(1, 22, 22, 1, 1, 0, 0);  // diff = TOL, still in tolerance
    add(1, 19, 19, 1, 0, 1, 0);  // diff = TOL+1 while locked
    add(1, 19, 19, 1, 0, 0, 0);  // match 1
    add(1, 16, 16, 1, 0, 1, 0);  // mismatch in TRACK clears match count
    add(1, 16, 16, 1, 0, 0, 0);
    add(1, 16, 16, 1, 0, 0, 0);
    add(1, 16, 16, 1, 0, 0, 0);
    add(1, 16, 16, 1, 1, 0, 0);  // needs four fresh matches
    add(0, 65, 0,  0, 0, 0, 1);  // frozen line: stuck pulse, back to IDLE
    add(1, 10, 0,  0, 0, 0, 0);  // IDLE -> MEAS
    add(1, 12, 12, 1, 0, 0, 0);  // measurement resumes
    add(1, 12, 12, 1, 0, 0, 0);
    add(1, 65, 65, 1, 0, 1, 0);  // edge exactly at cnt==TIMEOUT: no stuck

    // Reset hold with a toggling line.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      led_in = ~led_in;
      step();
      chk($sformatf("reset_hold_%0d", i),
          {25'd0, edge_pulse, level, period_vld, locked, mismatch, stuck, |half_period}, 32'd0);
    end
    led_in = 1'b0;
    step();
    rst = 1'b1;

    bad = 0;
    repeat (100) begin
      step();
      if (stuck || edge_pulse || period_vld || locked || mismatch || half_period != '0) bad++;
    end
    chk("idle_quiet", bad, 0);

    foreach (vecs[i]) begin
      bad = 0;
      repeat (vecs[i].gap - 1) begin
        step();
        if (edge_pulse || period_vld || mismatch || stuck) bad++;
      end
      if (vecs[i].tgl) led_in = ~led_in;
      step();
      chk($sformatf("v%0d_gap_quiet", i), bad, 0);
      chk($sformatf("v%0d_edge_pulse", i), edge_pulse, vecs[i].tgl);
      chk($sformatf("v%0d_level", i), level, led_in);
      chk($sformatf("v%0d_half_period", i), half_period, vecs[i].hp);
      chk($sformatf("v%0d_period_vld", i), period_vld, vecs[i].vld);
      chk($sformatf("v%0d_locked", i), locked, vecs[i].lck);
      chk($sformatf("v%0d_mismatch", i), mismatch, vecs[i].mis);
      chk($sformatf("v%0d_stuck", i), stuck, vecs[i].stk);
    end

    // Asynchronous reset mid-operation (half_period is 65 here).
    rst = 1'b0;
    #1;
    chk("async_reset",
        {25'd0, edge_pulse, level, period_vld, locked, mismatch, stuck, |half_period}, 32'd0);
    step();
    step();

    // Release with led_in=1: first sample counts as an edge.
    led_in = 1'b1;
    rst    = 1'b1;
    step();
    chk("first_sample_edge", edge_pulse, 1);
    chk("first_sample_level", level, 1);
    chk("first_sample_no_vld", period_vld, 0);

    // Narrow instance: edge at cnt==63 gives interval 64, clipped to 63.
    bad = 0;
    repeat (63) begin
      step();
      if (stuck || stuck2 || period_vld || vld2) bad++;
    end
    chk("clip_gap_quiet", bad, 0);
    led_in = 1'b0;
    step();
    chk("wide_half_period", half_period, 64);
    chk("wide_period_vld", period_vld, 1);
    chk("clip_half_period", hp2, 63);
    chk("clip_period_vld", vld2, 1);
    chk("clip_no_stuck", stuck2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
